// File: rtl/aes_pkg.sv
// Shared AES datapath types and helpers: state width, round count and round-key slicing.
package aes_pkg;
  localparam int NB        = 4;
  localparam int STATE_W   = 128;
  localparam int MAX_NR    = 14;
  localparam int MAX_KEY_W = STATE_W * (MAX_NR + 1);

  typedef logic [STATE_W-1:0] state_t;

  // Payload carried through the skid buffer: result plus its bookkeeping flags.
  typedef struct packed {
    state_t     st;
    logic [3:0] rnd;
    logic       last;
    logic       err;
  } ark_beat_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  // Round r sits at [KEY_W-1-128*r -: 128]; with the key zero-extended to
  // MAX_KEY_W that is the slice 128*(nr-r) bits above the LSB.
  function automatic state_t round_key(input logic [MAX_KEY_W-1:0] key,
                                       input logic [3:0] r,
                                       input logic [3:0] nr);
    int sh;
    if (r > nr) return '0;
    sh = STATE_W * (int'(nr) - int'(r));
    return key[sh +: STATE_W];
  endfunction
endpackage

// File: rtl/aes_skid_buf.sv
// Two-entry valid/ready skid buffer: output register plus one overflow entry.
// in_ready is a register that means "overflow entry is free".
module aes_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_vld;
  logic [W-1:0] skid_data;
  logic         acc, load;

  assign acc  = in_valid && in_ready;
  assign load = !out_valid || out_ready;

  // Output register refills from the skid entry first, else straight from the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      in_ready  <= 1'b0;
    end else if (load) begin
      in_ready <= 1'b1;
      if (skid_vld) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        skid_vld  <= 1'b0;
      end else if (acc) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_vld  <= 1'b1;
      skid_data <= in_data;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= !skid_vld;
    end
  end
endmodule

// File: rtl/add_round_key_pipe.sv
// Registered AddRoundKey stage: selects the round key (explicit or auto-counted
// round), XORs it into the state at acceptance and queues the result in a skid buffer.
module add_round_key_pipe
  import aes_pkg::*;
#(
  parameter  int NK    = 4,
  localparam int NR    = nr_of(NK),
  localparam int KEY_W = 128 * (NR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [3:0]       in_round,
  input  logic [KEY_W-1:0] key,
  input  logic             auto_mode,
  input  logic             dir,
  input  logic             restart,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [3:0]       out_round,
  output logic             out_last,
  output logic             out_err
);
  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("add_round_key_pipe: NK must be 4, 6 or 8");
  end

  localparam logic [3:0] NR4 = 4'(NR);

  logic       acc;
  logic [3:0] cnt, base, nxt, rnd;
  ark_beat_t  beat_in, beat_out;

  assign acc = in_valid && in_ready;

  // Round selection and key XOR; a restart in the same cycle overrides the counter.
  always_comb begin
    base = restart ? (dir ? NR4 : 4'd0) : cnt;
    if (dir) nxt = (base == 4'd0) ? NR4 : base - 4'd1;
    else     nxt = (base == NR4) ? 4'd0 : base + 4'd1;
    rnd          = auto_mode ? base : in_round;
    beat_in.rnd  = rnd;
    beat_in.err  = !auto_mode && (in_round > NR4);
    beat_in.last = auto_mode ? (dir ? (base == 4'd0) : (base == NR4)) : (in_round == NR4);
    beat_in.st   = beat_in.err ? in_state
                               : in_state ^ round_key(MAX_KEY_W'(key), rnd, NR4);
  end

  // Auto-mode round counter: steps on accepted auto beats, reloads on restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (acc && auto_mode)  cnt <= nxt;
    else if (restart)           cnt <= base;
  end

  aes_skid_buf #(.W($bits(ark_beat_t))) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (beat_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (beat_out)
  );

  assign out_state = beat_out.st;
  assign out_round = beat_out.rnd;
  assign out_last  = beat_out.last;
  assign out_err   = beat_out.err;
endmodule

// File: tb/tb_add_round_key_pipe.sv
// Bench for add_round_key_pipe: three instances (NK=4/6/8) share the stimulus;
// a queue-based reference model predicts every output beat.
module tb_add_round_key_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, auto_mode = 1'b0, dir = 1'b0, restart = 1'b0, out_ready = 1'b1;
  logic [127:0] in_state = '0;
  logic [3:0]   in_round = '0;
  logic [1407:0] key4;
  logic [1663:0] key6;
  logic [1919:0] key8;

  logic         rdy [3];
  logic         ov [3];
  logic         olast [3];
  logic         oerr [3];
  logic [127:0] ost [3];
  logic [3:0]   ornd [3];
  logic [127:0] rk [3][15];

  add_round_key_pipe #(.NK(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_state(in_state),
    .in_round(in_round), .key(key4), .auto_mode(auto_mode), .dir(dir), .restart(restart),
    .out_valid(ov[0]), .out_ready(out_ready), .out_state(ost[0]), .out_round(ornd[0]),
    .out_last(olast[0]), .out_err(oerr[0]));
  add_round_key_pipe #(.NK(6)) u6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_state(in_state),
    .in_round(in_round), .key(key6), .auto_mode(auto_mode), .dir(dir), .restart(restart),
    .out_valid(ov[1]), .out_ready(out_ready), .out_state(ost[1]), .out_round(ornd[1]),
    .out_last(olast[1]), .out_err(oerr[1]));
  add_round_key_pipe #(.NK(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_state(in_state),
    .in_round(in_round), .key(key8), .auto_mode(auto_mode), .dir(dir), .restart(restart),
    .out_valid(ov[2]), .out_ready(out_ready), .out_state(ost[2]), .out_round(ornd[2]),
    .out_last(olast[2]), .out_err(oerr[2]));

  int nvec = 0, nbad = 0;
  int acc_cnt = 0, out_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    nvec++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [127:0] st [3];
    int           rnd [3];
    logic         last [3];
    logic         err [3];
  } exp_t;

  exp_t         q[$];
  exp_t         me, pe;
  int           cnt_m [3];
  int           mr, mn;
  logic [3:0]   seq8[$];
  logic         stl = 1'b0;
  logic [127:0] ps;
  logic [5:0]   pf;

  // Handshakes are evaluated mid-cycle: inputs change just after the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 3; i++) cnt_m[i] = 0;
      stl = 1'b0;
    end else begin
      if (stl) begin
        chk("stall hold state", ost[0], ps);
        chk("stall hold flags", 128'({ornd[0], olast[0], oerr[0]}), 128'(pf));
      end
      if (ov[0] && out_ready) begin
        out_cnt++;
        seq8.push_back(ornd[2]);
        if (q.size() == 0) begin
          chk("spurious beat", 128'(1), 128'(0));
        end else begin
          pe = q.pop_front();
          for (int i = 0; i < 3; i++) begin
            chk($sformatf("nk%0d valid", 4 + 2 * i), 128'(ov[i]), 128'(1));
            chk($sformatf("nk%0d state", 4 + 2 * i), ost[i], pe.st[i]);
            chk($sformatf("nk%0d round", 4 + 2 * i), 128'(ornd[i]), 128'(pe.rnd[i]));
            chk($sformatf("nk%0d last/err", 4 + 2 * i), 128'({olast[i], oerr[i]}),
                128'({pe.last[i], pe.err[i]}));
          end
        end
      end
      stl = ov[0] && !out_ready;
      ps  = ost[0];
      pf  = {ornd[0], olast[0], oerr[0]};
      if (in_valid && rdy[0]) begin
        acc_cnt++;
        for (int i = 0; i < 3; i++) begin
          mn = 10 + 2 * i;
          if (auto_mode) begin
            mr = restart ? (dir ? mn : 0) : cnt_m[i];
            me.err[i]  = 1'b0;
            me.last[i] = dir ? (mr == 0) : (mr == mn);
            me.st[i]   = in_state ^ rk[i][mr];
            cnt_m[i]   = dir ? (mr + mn) % (mn + 1) : (mr + 1) % (mn + 1);
          end else begin
            mr = int'(in_round);
            me.err[i]  = mr > mn;
            me.last[i] = mr == mn;
            me.st[i]   = (mr > mn) ? in_state : in_state ^ rk[i][mr];
            if (restart) cnt_m[i] = dir ? mn : 0;
          end
          me.rnd[i] = mr;
        end
        q.push_back(me);
      end else if (restart) begin
        for (int i = 0; i < 3; i++) cnt_m[i] = dir ? 10 + 2 * i : 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    restart   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  typedef struct {
    int           inst;
    logic [3:0]   rnd;
    logic [127:0] st;
    logic [127:0] xs;
    logic         xl;
    logic         xe;
  } vec_t;

  vec_t tv [6];
  int   a0, o0;

  initial begin
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < 15; r++)
        rk[i][r] = {$urandom, $urandom, $urandom, $urandom};
    rk[0][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[0][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[0][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rk[1][12] = 128'h000102030405060708090a0b0c0d0e0f;
    for (int r = 0; r <= 10; r++) key4[1407 - 128 * r -: 128] = rk[0][r];
    for (int r = 0; r <= 12; r++) key6[1663 - 128 * r -: 128] = rk[1][r];
    for (int r = 0; r <= 14; r++) key8[1919 - 128 * r -: 128] = rk[2][r];

    tv[0] = '{0, 4'd0,  128'h3243f6a8885a308d313198a2e0370734,
              128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 1'b0};
    tv[1] = '{0, 4'd1,  128'h046681e5e0cb199a48f8d37a2806264c,
              128'ha49c7ff2689f352b6b5bea43026a5049, 1'b0, 1'b0};
    tv[2] = '{1, 4'd13, 128'hdeadbeef00112233445566778899aabb,
              128'hdeadbeef00112233445566778899aabb, 1'b0, 1'b1};
    tv[3] = '{1, 4'd12, 128'h0,
              128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0};
    tv[4] = '{2, 4'd15, 128'hcafef00d0000000000000000abcdef01,
              128'hcafef00d0000000000000000abcdef01, 1'b0, 1'b1};
    tv[5] = '{0, 4'd10, 128'h0,
              128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 1'b0};

    // reset state
    tick();
    chk("reset out_valid", 128'(ov[0]), 128'(0));
    chk("reset out_state", ost[0], 128'h0);
    chk("reset out_round/last/err", 128'({ornd[0], olast[0], oerr[0]}), 128'(0));
    chk("reset in_ready", 128'(rdy[0]), 128'(0));
    tick();
    rst = 1'b0;
    chk("in_ready before first edge", 128'(rdy[0]), 128'(0));
    tick();
    chk("in_ready after first edge", 128'(rdy[0]), 128'(1));

    // explicit-mode table
    for (int k = 0; k < 6; k++) begin
      auto_mode = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_round  = tv[k].rnd;
      in_state  = tv[k].st;
      tick();
      in_valid = 1'b0;
      chk($sformatf("tv%0d valid", k), 128'(ov[tv[k].inst]), 128'(1));
      chk($sformatf("tv%0d state", k), ost[tv[k].inst], tv[k].xs);
      chk($sformatf("tv%0d round", k), 128'(ornd[tv[k].inst]), 128'(tv[k].rnd));
      chk($sformatf("tv%0d last", k), 128'(olast[tv[k].inst]), 128'(tv[k].xl));
      chk($sformatf("tv%0d err", k), 128'(oerr[tv[k].inst]), 128'(tv[k].xe));
    end
    drain();

    // auto decrypt, NK=8: 14..0 then wrap to 14
    auto_mode = 1'b1;
    dir       = 1'b1;
    restart   = 1'b1;
    tick();
    restart = 1'b0;
    seq8.delete();
    in_state = '0;
    in_valid = 1'b1;
    repeat (16) tick();
    drain();
    chk("dec seq length", 128'(seq8.size()), 128'(16));
    for (int j = 0; j < 16 && j < seq8.size(); j++)
      chk($sformatf("dec seq[%0d]", j), 128'(seq8[j]), 128'((j < 15) ? 14 - j : 14));

    // backpressure: stall 3 edges with input streaming
    dir = 1'b0;
    restart = 1'b1;
    tick();
    restart   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a0 = acc_cnt;
    for (int j = 0; j < 3; j++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (j >= 1) chk($sformatf("bp in_ready low %0d", j), 128'(rdy[0]), 128'(0));
    end
    chk("bp absorbed", 128'(acc_cnt - a0), 128'(2));
    out_ready = 1'b1;
    repeat (2) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    o0 = out_cnt;
    repeat (10) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    chk("bp throughput", 128'(out_cnt - o0), 128'(10));
    drain();

    // randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      auto_mode = 1'($urandom_range(0, 1));
      restart   = 1'($urandom_range(0, 15) == 0);
      if (restart) dir = 1'($urandom_range(0, 1));
      in_round  = 4'($urandom_range(0, 15));
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    drain();

    // reset mid-stream with output held and skid full
    auto_mode = 1'b1;
    dir       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("pre-reset out_valid", 128'(ov[0]), 128'(1));
    chk("pre-reset skid full", 128'(rdy[0]), 128'(0));
    #2 rst = 1'b1;
    #1;
    chk("async reset out_valid", 128'(ov[0]), 128'(0));
    chk("async reset out_state", ost[0], 128'h0);
    chk("async reset in_ready", 128'(rdy[0]), 128'(0));
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("post-reset in_ready low", 128'(rdy[0]), 128'(0));
    tick();
    chk("post-reset in_ready high", 128'(rdy[0]), 128'(1));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post-reset counter nk4", 128'(ornd[0]), 128'(0));
    chk("post-reset counter nk8", 128'(ornd[2]), 128'(0));
    drain();
    chk("scoreboard empty", 128'(q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/add_round_key_pipe.md
Name: add_round_key_pipe

Overview:
- Registered, handshaked AddRoundKey stage for the AES datapath, parametrised over key size (AES-128/192/256).
- Selects the 128-bit round key from the flat expanded-key vector. The round index comes from the caller (explicit mode) or from an internal counter stepping up (encrypt) or down (decrypt) (auto mode).
- Sits between the round-function datapath and the cipher controller. A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8; any other value is an elaboration error.
- NR, NK+6, number of rounds; derived, not overridable.
- KEY_W, 128*(NR+1), width of the flat expanded-key vector.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_state  input  128  state; byte 0 is in bits [127:120], column-major.
- in_round  input  4  round index; used in explicit mode only.
- key  input  KEY_W  expanded key; round r occupies [KEY_W-1-128*r -: 128]. Must be held stable while beats are in flight.
- auto_mode  input  1  1 = internal round counter, 0 = in_round.
- dir  input  1  auto mode only: 0 = encrypt (0 up to NR), 1 = decrypt (NR down to 0).
- restart  input  1  one-cycle pulse; reloads the round counter.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream ready.
- out_state  output  128  in_state XOR selected round key.
- out_round  output  4  round index actually used.
- out_last  output  1  beat used the final round (NR when encrypting, 0 when decrypting; explicit mode: round==NR).
- out_err  output  1  explicit in_round > NR; out_state = in_state unmodified.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_state=0, out_round=0, out_last=0, out_err=0.
  - in_ready=0; in_ready rises on the first clk edge after rst deasserts.
  - Both skid entries are emptied; round counter = 0.
  - Reset mid-operation drops all in-flight beats with no output.
- Latency: a beat accepted at edge t is presented on out_* after edge t (one cycle) when the output register is empty or draining.
- Throughput: one beat per cycle while out_ready=1.
- Handshake:
  - out_* stay stable while out_valid && !out_ready.
  - in_ready is registered and equals "skid entry free".
  - A beat accepted while the output is stalled goes to the skid entry.
  - in_ready drops the cycle after the skid entry fills and returns the cycle after it drains.
- Compute: the XOR and key select are done at acceptance; the stored result is carried with its round, last and err flags.
- Round counter (auto mode):
  - Advances only on an accepted beat.
  - Encrypt: 0,1,…,NR then wraps to 0.
  - Decrypt: NR,…,0 then wraps to NR.
  - out_last=1 on the wrap beat.
- restart:
  - Loads the counter with 0 (dir=0) or NR (dir=1), taking effect for the next accepted beat.
  - If restart and acceptance occur in the same cycle, the beat uses the reloaded value and the counter advances from it.
- Changing dir without restart is undefined for the counter; no protection is required.
- Explicit mode:
  - Counter is untouched.
  - in_round > NR: out_err=1, out_state=in_state, out_round=in_round.
- Concurrent events: a simultaneous output drain and input accept with an empty skid passes straight through with no bubble.

Decomposition:
- Package aes_pkg:
  - constants NB=4 and STATE_W=128;
  - function nr_of(nk);
  - function round_key(key, r, nr) returning the 128-bit slice;
  - typedef for the 128-bit state.
- Sub-module aes_skid_buf: generic 2-entry valid/ready skid buffer, parametrised by payload width. Here the payload is 128+4+1+1 bits.
- The counter and XOR/select logic live in add_round_key_pipe.

Test Plan:
- Explicit mode, NK=4:
  - in_round=0, in_state=3243f6a8885a308d313198a2e0370734, round-0 key=2b7e151628aed2a6abf7158809cf4f3c -> out_state=193de3bea0f4e22b9ac68d2ae9f84808 one cycle later, out_last=0, out_err=0.
- Explicit mode, NK=4, in_round=1:
  - in_state=046681e5e0cb199a48f8d37a2806264c, round-1 key=a0fafe1788542cb123a339392a6c7605 -> out_state=a49c7ff2689f352b6b5bea43026a5049.
- Auto mode, NK=8, dir=1:
  - restart, then 16 beats with in_state=0 -> out_round sequence 14..0,14; out_last only on the round-0 beat; each out_state equals that round's key slice.
- Backpressure:
  - out_ready=0 for 3 cycles with in_valid=1 continuously -> exactly 2 beats absorbed, in_ready=0 from the next cycle.
  - out_ready=1 -> beats emerge in order, none lost or duplicated, 1 beat/cycle afterwards.
- Error:
  - NK=6, in_round=13 -> out_err=1, out_state=in_state.
  - in_round=12 -> out_last=1, out_err=0.
- Reset mid-stream:
  - rst asserted asynchronously between edges with out_valid=1 and a full skid entry -> out_valid=0 immediately.
  - in_ready=0 during reset, then 1 one edge after release.
  - Round counter = 0.
